mempool_ctrl_responder: RTL

AXI responder that terminates one tile-side AXI master port (`axi_tile_req_t`/`axi_tile_resp_t`) and implements MemPool's cluster control registers. Writes to its WAKE_UP register generate the per-core `wake_up` pulses consumed by the MemPool cluster. Its EOC register drives the end-of-computation flag. It handles one transaction at a time, with full burst support. It sits between the system-level AXI crossbar and the cluster's `wake_up_i` input.

---
 rtl/mempool_ctrl_responder.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mempool_ctrl_responder.sv
// MemPool cluster control registers behind a single-transaction AXI responder.
// Generates per-core wake-up pulses and holds the end-of-computation flag.

package mempool_ctrl_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [IdWidth-1:0] id_t;

    typedef struct packed {
        id_t                  id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } axi_ax_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } axi_w_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        id_t                  id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_tile_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_tile_resp_t;

endpackage

// AxiDataWidth must match the package data width the AXI structs are built with.
module mempool_ctrl_responder
    import mempool_ctrl_pkg::*;
#(
    parameter int unsigned NumCores     = 1,
    parameter int unsigned AxiDataWidth = DataWidth
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  axi_tile_req_t       axi_slv_req_i,
    output axi_tile_resp_t      axi_slv_resp_o,
    output logic [NumCores-1:0] wake_up_o,
    output logic [31:0]         eoc_o
);

    localparam int unsigned NumLanes = AxiDataWidth / 32;
    localparam int unsigned LaneBits = (NumLanes > 1) ? $clog2(NumLanes) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

    state_e               state_q, state_d;
    id_t                  id_q;
    logic [11:0]          addr_q;
    logic [7:0]           len_q;
    logic [7:0]           beat_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic                 err_q;
    logic [31:0]          eoc_q;
    logic [31:0]          scratch_q;
    logic [NumCores-1:0]  wake_q;

    logic                 aw_hs, ar_hs, w_hs, r_hs;
    logic                 last_beat;
    logic [11:0]          next_addr;
    logic [LaneBits-1:0]  lane_sel;
    logic [9:0]           reg_sel;
    logic                 sel_err;
    logic [31:0]          wdata_lane;
    logic [3:0]           wstrb_lane;
    logic [31:0]          wake_val;
    logic [NumCores-1:0]  wake_d;
    logic [31:0]          rdata_word;
    logic                 unused;

    assign unused = ^{axi_slv_req_i.w.last, axi_slv_req_i.aw.addr[AddrWidth-1:12],
                      axi_slv_req_i.ar.addr[AddrWidth-1:12]};

    assign aw_hs     = (state_q == IDLE) && axi_slv_req_i.aw_valid;
    assign ar_hs     = (state_q == IDLE) && !axi_slv_req_i.aw_valid && axi_slv_req_i.ar_valid;
    assign w_hs      = (state_q == WRITE) && axi_slv_req_i.w_valid;
    assign r_hs      = (state_q == READ) && axi_slv_req_i.r_ready;
    assign last_beat = (beat_q == len_q);
    // WRAP bursts advance like INCR; the 12-bit counter wraps within the 4 KiB window.
    assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (12'd1 << size_q);
    assign lane_sel  = (NumLanes > 1) ? addr_q[LaneBits+1:2] : '0;
    assign reg_sel   = addr_q[11:2];
    assign sel_err   = (reg_sel > 10'd3);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        wdata_lane = '0;
        wstrb_lane = '0;
        for (int l = 0; l < NumLanes; l++) begin
            if (lane_sel == LaneBits'(l)) begin
                wdata_lane = axi_slv_req_i.w.data[32*l +: 32];
                wstrb_lane = axi_slv_req_i.w.strb[4*l +: 4];
            end
        end
    end

    // Wake-up decode uses the strobed value with unstrobed bytes taken as zero.
    always_comb begin
        wake_val = merge_bytes(32'd0, wdata_lane, wstrb_lane);
        wake_d   = '0;
        if (wake_val == 32'hFFFF_FFFF) begin
            wake_d = '1;
        end else begin
            for (int c = 0; c < NumCores; c++) begin
                if (wake_val == 32'(c)) begin
                    wake_d[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdata_word = '0;
        case (reg_sel)
            10'd1:   rdata_word = eoc_q;
            10'd2:   rdata_word = scratch_q;
            10'd3:   rdata_word = 32'(NumCores);
            default: rdata_word = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (axi_slv_req_i.aw_valid) begin
                    state_d = WRITE;
                end else if (axi_slv_req_i.ar_valid) begin
                    state_d = READ;
                end
            end
            WRITE: if (axi_slv_req_i.w_valid && last_beat) state_d = WRESP;
            WRESP: if (axi_slv_req_i.b_ready) state_d = IDLE;
            READ:  if (axi_slv_req_i.r_ready && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction bookkeeping and register file; wake_q defaults to zero so pulses last one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            eoc_q     <= '0;
            scratch_q <= '0;
            wake_q    <= '0;
        end else begin
            wake_q <= '0;
            if (aw_hs) begin
                id_q    <= axi_slv_req_i.aw.id;
                addr_q  <= axi_slv_req_i.aw.addr[11:0];
                len_q   <= axi_slv_req_i.aw.len;
                size_q  <= axi_slv_req_i.aw.size;
                burst_q <= axi_slv_req_i.aw.burst;
                beat_q  <= '0;
                err_q   <= 1'b0;
            end else if (ar_hs) begin
                id_q    <= axi_slv_req_i.ar.id;
                addr_q  <= axi_slv_req_i.ar.addr[11:0];
                len_q   <= axi_slv_req_i.ar.len;
                size_q  <= axi_slv_req_i.ar.size;
                burst_q <= axi_slv_req_i.ar.burst;
                beat_q  <= '0;
                err_q   <= 1'b0;
            end
            if (w_hs) begin
                beat_q <= beat_q + 8'd1;
                addr_q <= next_addr;
                if (sel_err) begin
                    err_q <= 1'b1;
                end
                case (reg_sel)
                    10'd0:   wake_q    <= wake_d;
                    10'd1:   eoc_q     <= merge_bytes(eoc_q, wdata_lane, wstrb_lane);
                    10'd2:   scratch_q <= merge_bytes(scratch_q, wdata_lane, wstrb_lane);
                    default: ;
                endcase
            end
            if (r_hs) begin
                beat_q <= beat_q + 8'd1;
                addr_q <= next_addr;
            end
        end
    end

    always_comb begin
        axi_slv_resp_o          = '0;
        axi_slv_resp_o.aw_ready = !rst_i && (state_q == IDLE);
        axi_slv_resp_o.ar_ready = !rst_i && (state_q == IDLE) && !axi_slv_req_i.aw_valid;
        axi_slv_resp_o.w_ready  = !rst_i && (state_q == WRITE);
        axi_slv_resp_o.b_valid  = !rst_i && (state_q == WRESP);
        axi_slv_resp_o.b.id     = id_q;
        axi_slv_resp_o.b.resp   = err_q ? RESP_SLVERR : RESP_OKAY;
        axi_slv_resp_o.r_valid  = !rst_i && (state_q == READ);
        axi_slv_resp_o.r.id     = id_q;
        axi_slv_resp_o.r.data   = {NumLanes{rdata_word}};
        axi_slv_resp_o.r.resp   = sel_err ? RESP_SLVERR : RESP_OKAY;
        axi_slv_resp_o.r.last   = last_beat;
    end

    assign wake_up_o = rst_i ? '0 : wake_q;
    assign eoc_o     = eoc_q;

endmodule
